// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Collects a three-byte command (opcode, operand A, operand B) from a
// valid/ready byte stream, presents the operands and opcode to an external
// combinational ALU, captures its result and offers it on a valid/ready
// result port together with illegal/zero flags.
//
// Optional feature (compile-time macro ALU_SEQ_ACCUM_EN):
//   Adds an 8-bit accumulator that is loaded with every legal result.
//   Opcodes 8..11 then become accumulator commands: the A byte is not
//   requested, alu_a is taken from the accumulator and the ALU sees
//   opcode {1'b0, opcode[2:0]}. Opcodes 12..15 remain illegal.
//   With the macro undefined there is no accumulator and 4..15 are illegal.
//
// Parameters:
//   IDLE_TIMEOUT  cycles a partial command may stall waiting for an operand
//                 byte before it is discarded; 0 disables the timeout.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data      command/operand byte
//   in_valid     byte offered
//   in_ready     byte accepted (IDLE, GET_A, GET_B only)
//   alu_a/alu_b  registered operands to the ALU
//   alu_opcode   registered opcode to the ALU (valid from ISSUE through HOLD)
//   alu_result   combinational ALU result
//   out_data     captured result (0x00 for an illegal opcode)
//   out_valid    result offered; held until out_ready
//   out_ready    result accepted
//   out_illegal  opcode was illegal (qualified by out_valid)
//   out_zero     legal result equal to zero (qualified by out_valid)
//   busy         a command is in progress (state != IDLE)
//   timeout      one-cycle pulse when a stalled partial command is dropped
//
// Timing: the B byte transfers at edge T, ISSUE occupies [T, T+1), and
// out_valid is registered at T+1, so a consumer first samples it high at the
// second rising edge after the B transfer. A timeout is registered at the end
// of the IDLE_TIMEOUT-th consecutive stalled cycle; a byte transferring in
// that same cycle takes priority.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_result,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_illegal,
  output logic       out_zero,
  output logic       busy,
  output logic       timeout
);

  localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IDLE_TIMEOUT);
  localparam bit TIMEOUT_EN = (IDLE_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_ISSUE,
    S_HOLD
  } state_t;

  state_t           state;
  logic [3:0]       opcode_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             cnt_expired;
  logic             xfer;
  logic             op_is_accum;
  logic             op_legal;
  logic [3:0]       issue_opcode;

`ifdef ALU_SEQ_ACCUM_EN
  logic [7:0] acc;
  logic       in_is_accum;

  assign in_is_accum = in_data[3] & (in_data[2:0] <= 3'd3);
  assign op_is_accum = opcode_q[3] & (opcode_q[2:0] <= 3'd3);
`else
  assign op_is_accum = 1'b0;
`endif

  // in_ready is decoded straight from the state register so a sender sees
  // back-pressure in ISSUE/HOLD without an extra cycle of delay.
  assign in_ready = (state == S_IDLE) | (state == S_GET_A) | (state == S_GET_B);
  assign xfer     = in_valid & in_ready;

  assign op_legal     = (opcode_q <= 4'd3) | op_is_accum;
  assign issue_opcode = op_is_accum ? {1'b0, opcode_q[2:0]} : opcode_q;

  // Expiry means this stalled cycle would be the IDLE_TIMEOUT-th in a row.
  assign wait_cnt_inc = wait_cnt + CNT_W'(1);
  assign cnt_expired  = TIMEOUT_EN && (wait_cnt_inc == CNT_LIMIT);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values; blocking assignments would make the
  // result depend on statement order and mismatch between sim and synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      opcode_q    <= '0;
      wait_cnt    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
      out_zero    <= 1'b0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            opcode_q <= in_data[3:0];
            wait_cnt <= '0;
            busy     <= 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
            if (in_is_accum) begin
              alu_a <= acc;
              state <= S_GET_B;
            end else begin
              state <= S_GET_A;
            end
`else
            state <= S_GET_A;
`endif
          end
        end

        S_GET_A: begin
          if (xfer) begin
            alu_a    <= in_data;
            wait_cnt <= '0;
            state    <= S_GET_B;
          end else if (cnt_expired) begin
            timeout  <= 1'b1;
            wait_cnt <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end

        S_GET_B: begin
          if (xfer) begin
            alu_b      <= in_data;
            alu_opcode <= issue_opcode;
            wait_cnt   <= '0;
            state      <= S_ISSUE;
          end else if (cnt_expired) begin
            timeout  <= 1'b1;
            wait_cnt <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end

        S_ISSUE: begin
          // Illegal opcodes still consume both operands but report 0x00.
          out_data    <= op_legal ? alu_result : 8'h00;
          out_illegal <= ~op_legal;
          out_zero    <= op_legal & (alu_result == 8'h00);
          out_valid   <= 1'b1;
          state       <= S_HOLD;
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        // NOTE: the default arm returns an unreachable encoding to IDLE and
        // gives every path through the case a defined next state.
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ACCUM_EN
  // The accumulator follows the result of every legal command as it is
  // captured, so a chained accumulator command sees it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00;
    end else if ((state == S_ISSUE) && op_legal) begin
      acc <= alu_result;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer (IDLE_TIMEOUT = 4). The external ALU is
// modelled as 0:add 1:and 2:or 3:xor (other codes return a junk value). A
// transaction-level model turns each command into its expected result; a
// negedge monitor checks every result, hold stability and timeout pulses.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int TO = 4;
`ifdef ALU_SEQ_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_illegal;
  logic       out_zero;
  logic       busy;
  logic       timeout;

  alu_op_sequencer #(.IDLE_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_illegal(out_illegal),
    .out_zero   (out_zero),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    case (alu_opcode)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a & alu_b;
      4'd2:    alu_result = alu_a | alu_b;
      4'd3:    alu_result = alu_a ^ alu_b;
      default: alu_result = 8'hA5;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_timeouts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [7:0] data;
    logic       ill;
    logic       zero;
    logic [3:0] aop;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_acc = 8'h00;

  function automatic logic acc_cmd(input logic [3:0] op);
    return ACC_EN && op[3] && (op[2:0] <= 3'd3);
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] acc);
    exp_t e;
    logic [7:0] x;
    logic [7:0] r;
    x = acc_cmd(op) ? acc : a;
    case (op[1:0])
      2'd0:    r = x + b;
      2'd1:    r = x & b;
      2'd2:    r = x | b;
      default: r = x ^ b;
    endcase
    if (op < 4'd4 || acc_cmd(op)) begin
      e.data = r;
      e.ill  = 1'b0;
      e.zero = (r == 8'h00);
    end else begin
      e.data = 8'h00;
      e.ill  = 1'b1;
      e.zero = 1'b0;
    end
    e.aop = acc_cmd(op) ? {1'b0, op[2:0]} : op;
    return e;
  endfunction

  task automatic push_exp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e = model(op, a, b, m_acc);
    if (ACC_EN && !e.ill) m_acc = e.data;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- driver
  // Called and returns at posedge + #1; the byte transfers at the last edge.
  task automatic send_byte(input logic [7:0] b);
    logic hs;
    int   n;
    hs = 1'b0;
    n  = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!hs) check("send_byte_accepted", 32'(hs), 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    send_byte(op);
    if (!acc_cmd(op[3:0])) send_byte(a);
    send_byte(b);
    push_exp(op[3:0], a, b);
  endtask

  task automatic expect_result(input logic [7:0] d, input logic ill, input logic zero,
                               input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, "_valid"},   32'(out_valid),   32'd1);
    check({name, "_data"},    32'(out_data),    32'(d));
    check({name, "_illegal"}, 32'(out_illegal), 32'(ill));
    check({name, "_zero"},    32'(out_zero),    32'(zero));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, "_alu_a"},      32'(alu_a),       32'd0);
    check({name, "_alu_b"},      32'(alu_b),       32'd0);
    check({name, "_alu_opcode"}, 32'(alu_opcode),  32'd0);
    check({name, "_out_data"},   32'(out_data),    32'd0);
    check({name, "_out_valid"},  32'(out_valid),   32'd0);
    check({name, "_illegal"},    32'(out_illegal), 32'd0);
    check({name, "_zero"},       32'(out_zero),    32'd0);
    check({name, "_busy"},       32'(busy),        32'd0);
    check({name, "_timeout"},    32'(timeout),     32'd0);
    exp_q.delete();
    m_acc = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  logic       pv  = 1'b0;
  logic       pr  = 1'b0;
  logic       pto = 1'b0;
  logic [7:0] pd  = 8'h00;
  logic       pil = 1'b0;
  logic       pz  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv  = 1'b0;
      pr  = 1'b0;
      pto = 1'b0;
    end else begin
      if (timeout) begin
        n_timeouts++;
        check("timeout_single_cycle", 32'(pto), 32'd0);
        check("timeout_no_valid", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        if (pv && !pr) begin
          check("hold_stable_data",    32'(out_data),    32'(pd));
          check("hold_stable_illegal", 32'(out_illegal), 32'(pil));
          check("hold_stable_zero",    32'(out_zero),    32'(pz));
        end else if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: out_valid high with no command pending, out_data=0x%02h", out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data",       32'(out_data),    32'(e.data));
          check("sb_illegal",    32'(out_illegal), 32'(e.ill));
          check("sb_zero",       32'(out_zero),    32'(e.zero));
          check("sb_alu_opcode", 32'(alu_opcode),  32'(e.aop));
        end
      end
      pv  = out_valid;
      pr  = out_ready;
      pd  = out_data;
      pil = out_illegal;
      pz  = out_zero;
      pto = timeout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    exp_t p;
    rst_n     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Pin the model with hand-computed values.
    p = model(4'h0, 8'h3C, 8'h0A, 8'h00);
    check("pin_add", 32'({p.ill, p.zero, p.data}), 32'h046);
    p = model(4'h3, 8'h5A, 8'h5A, 8'h00);
    check("pin_xor_zero", 32'({p.ill, p.zero, p.data}), 32'h100);
    p = model(4'h7, 8'hFF, 8'h01, 8'h00);
    check("pin_illegal", 32'({p.ill, p.zero, p.data}), 32'h200);
    p = model(4'h2, 8'hF0, 8'h0F, 8'h00);
    check("pin_or", 32'(p.data), 32'hFF);
    p = model(4'h1, 8'hCC, 8'hAA, 8'h00);
    check("pin_and", 32'(p.data), 32'h88);

    #1;
    do_reset("rst_init");

    // Add, with latency and ISSUE-cycle checks.
    send_cmd(8'h00, 8'h3C, 8'h0A);
    @(negedge clk);
    check("lat_issue_no_valid", 32'(out_valid), 32'd0);
    check("issue_alu_opcode", 32'(alu_opcode), 32'd0);
    check("issue_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("r030_data", 32'(out_data), 32'h46);
    check("r030_illegal", 32'(out_illegal), 32'd0);
    check("r030_zero", 32'(out_zero), 32'd0);
    @(posedge clk);
    #1;

    // Zero result held under back-pressure with the next byte already offered.
    out_ready = 1'b0;
    send_cmd(8'h03, 8'h5A, 8'h5A);
    expect_result(8'h00, 1'b0, 1'b1, "r031");
    in_data  = 8'h07;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("r031_hold_valid", 32'(out_valid), 32'd1);
      check("r031_hold_data", 32'(out_data), 32'h00);
      check("r031_hold_zero", 32'(out_zero), 32'd1);
      check("r031_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Illegal opcode; upper nibble of the opcode byte ignored.
    send_cmd(8'h07, 8'hFF, 8'h01);
    expect_result(8'h00, 1'b1, 1'b0, "r032");
    send_cmd(8'hF1, 8'h0F, 8'h3C);
    expect_result(8'h0C, 1'b0, 1'b0, "r032_hinib");

    // Stall in GET_A until the timeout fires, then recover.
    send_byte(8'h01);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("to_a_pulse", 32'(timeout), 32'(k == 5));
      if (k == 5) begin
        check("to_a_busy", 32'(busy), 32'd0);
        check("to_a_in_ready", 32'(in_ready), 32'd1);
      end
    end
    @(posedge clk);
    #1;
    send_cmd(8'h02, 8'hF0, 8'h0F);
    expect_result(8'hFF, 1'b0, 1'b0, "r033");

    // Stall in GET_B until the timeout fires.
    send_byte(8'h00);
    send_byte(8'h11);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("to_b_pulse", 32'(timeout), 32'(k == 5));
    end
    @(posedge clk);
    #1;

    // A byte in the very cycle the limit is reached wins over the timeout.
    send_byte(8'h02);
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'h30);
    @(negedge clk);
    check("edge_xfer_busy", 32'(busy), 32'd1);
    check("edge_xfer_no_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h03);
    push_exp(4'h2, 8'h30, 8'h03);
    expect_result(8'h33, 1'b0, 1'b0, "edge_xfer");

    // Reset while waiting for the B byte.
    send_byte(8'h01);
    send_byte(8'hCC);
    @(negedge clk);
    #1;
    do_reset("rst_get_b");
    send_cmd(8'h01, 8'hCC, 8'hAA);
    expect_result(8'h88, 1'b0, 1'b0, "r034");

    // Reset while a result is held; it must not reappear.
    out_ready = 1'b0;
    send_cmd(8'h00, 8'h01, 8'h01);
    expect_result(8'h02, 1'b0, 1'b0, "hold_pre_rst");
    do_reset("rst_hold");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_hold_dropped", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;

`ifdef ALU_SEQ_ACCUM_EN
    send_cmd(8'h00, 8'h10, 8'h05);
    expect_result(8'h15, 1'b0, 1'b0, "r035_first");
    send_cmd(8'h08, 8'h00, 8'h01);
    expect_result(8'h16, 1'b0, 1'b0, "r035_accum");
    send_cmd(8'h0C, 8'h01, 8'h02);
    expect_result(8'h00, 1'b1, 1'b0, "r035_accum_illegal");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("timeout_count", 32'(n_timeouts), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
